// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit: runs one word-level load or store over an 8-bit
// memory port and returns the extended load data or an access error.
module lsu_byte_serial #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;

  logic                r_write;
  logic [2:0]          r_funct3;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_last;

  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [BYTE_W-1:0]   r_mem_wdata;
  logic                r_busy;

  logic                w_accept;
  logic                w_req_err;
  logic [CNT_W-1:0]    w_req_last;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [DATA_W-1:0]   w_data_merged;

  logic                w_req_ready_nxt;
  logic                w_resp_valid_nxt;
  logic [DATA_W-1:0]   w_resp_rdata_nxt;
  logic                w_resp_err_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic                w_mem_we_nxt;
  logic [BYTE_W-1:0]   w_mem_wdata_nxt;
  logic                w_busy_nxt;

  function automatic logic [DATA_W-1:0] f_extend(input logic [2:0] f3,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] v;
    case (f3)
      3'b000:  v = {{24{d[7]}}, d[7:0]};
      3'b001:  v = {{16{d[15]}}, d[15:0]};
      3'b100:  v = {24'd0, d[7:0]};
      3'b101:  v = {16'd0, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  assign w_accept  = req_valid && r_req_ready;
  assign w_cnt_inc = CNT_W'(r_cnt + CNT_W'(1));

  // Legality/alignment of the incoming request and its last byte index
  always_comb begin
    w_req_err  = 1'b0;
    w_req_last = CNT_W'(0);
    case (req_funct3)
      3'b000:  w_req_err = 1'b0;
      3'b001:  w_req_err = req_addr[0];
      3'b010:  w_req_err = |req_addr[1:0];
      3'b100:  w_req_err = req_write;
      3'b101:  w_req_err = req_write | req_addr[0];
      default: w_req_err = 1'b1;
    endcase
    case (req_funct3[1:0])
      2'b00:   w_req_last = CNT_W'(0);
      2'b01:   w_req_last = CNT_W'(1);
      default: w_req_last = CNT_W'(3);
    endcase
  end

  // Load data with the byte currently on mem_rdata dropped into lane r_cnt
  always_comb begin
    w_data_merged = r_data;
    w_data_merged[{r_cnt, 3'b000} +: BYTE_W] = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_req_err ? S_RESP : S_XFER;
      S_XFER:  if (r_cnt == r_last) w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state
  always_comb begin
    w_req_ready_nxt  = (w_state_nxt == S_IDLE);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_resp_valid_nxt = (w_state_nxt == S_RESP);
    w_resp_rdata_nxt = '0;
    w_resp_err_nxt   = 1'b0;
    w_mem_addr_nxt   = '0;
    w_mem_we_nxt     = 1'b0;
    w_mem_wdata_nxt  = '0;
    if (w_state_nxt == S_RESP) begin
      case (r_state)
        S_RESP: begin
          w_resp_rdata_nxt = r_resp_rdata;
          w_resp_err_nxt   = r_resp_err;
        end
        S_XFER: begin
          w_resp_rdata_nxt = r_write ? '0 : f_extend(r_funct3, w_data_merged);
          w_resp_err_nxt   = 1'b0;
        end
        default: w_resp_err_nxt = 1'b1;
      endcase
    end
    if (w_state_nxt == S_XFER) begin
      if (r_state == S_IDLE) begin
        w_mem_addr_nxt  = req_addr;
        w_mem_we_nxt    = req_write;
        w_mem_wdata_nxt = req_write ? req_wdata[BYTE_W-1:0] : '0;
      end else begin
        w_mem_addr_nxt  = ADDR_W'(r_mem_addr + ADDR_W'(1));
        w_mem_we_nxt    = r_write;
        w_mem_wdata_nxt = r_write ? r_wdata[{w_cnt_inc, 3'b000} +: BYTE_W] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Request capture and byte sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_last   <= '0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_funct3 <= req_funct3;
      r_wdata  <= req_wdata;
      r_data   <= '0;
      r_cnt    <= '0;
      r_last   <= w_req_last;
    end else if (r_state == S_XFER) begin
      if (!r_write) r_data <= w_data_merged;
      r_cnt <= w_cnt_inc;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;

endmodule

// File: tb/tb_lsu_byte_serial.sv
// Scoreboard bench for lsu_byte_serial: byte memory model, directed scenarios
// and randomized requests checked against a word-level reference model.
module tb_lsu_byte_serial;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned MEM_SZ   = 4096;
  localparam int          MAX_WAIT = 200;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } mem_t;

  resp_t exp_q[$];
  mem_t  mem_q[$];
  resp_t mon_e;
  mem_t  mon_m;
  logic  seen;

  logic [7:0] mem     [MEM_SZ];
  logic [7:0] ref_mem [MEM_SZ];

  int   vectors;
  int   miscompares;
  int   cyc;
  logic rr_rand;
  logic rr_val;

  lsu_byte_serial #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: asynchronous read, write on the clock edge
  assign mem_rdata = mem[mem_addr[11:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:0]] = mem_wdata;

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: access size, legality and the loaded value
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic is_err(input logic w, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    legal = w ? (f3 inside {3'b000, 3'b001, 3'b010})
              : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (!legal) return 1'b1;
    return (addr % 32'(size_of(f3))) != 0;
  endfunction

  function automatic int mem_idx(input logic [31:0] a);
    return int'(a % 32'(MEM_SZ));
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr);
    longint v;
    v = 0;
    for (int i = 0; i < size_of(f3); i++)
      v += longint'(ref_mem[mem_idx(addr + 32'(i))]) << (8 * i);
    if (f3 == 3'b000 && v >= 128)   v -= 256;
    if (f3 == 3'b001 && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    mem[mem_idx(a)]     = v;
    ref_mem[mem_idx(a)] = v;
  endtask

  // Present one request (call just after a falling edge); returns on the first XFER/RESP cycle
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    resp_t e;
    mem_t  m;
    int    t;
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    t = 0;
    while (!req_ready && t < MAX_WAIT) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.err   = is_err(w, f3, addr);
    e.rdata = (e.err || w) ? 32'd0 : load_value(f3, addr);
    e.due   = cyc + 1 + (e.err ? 0 : size_of(f3));
    if (!e.err) begin
      for (int k = 0; k < size_of(f3); k++) begin
        m.addr  = addr + 32'(k);
        m.we    = w;
        m.wdata = wd[8*k +: 8];
        mem_q.push_back(m);
        if (w) ref_mem[mem_idx(m.addr)] = m.wdata;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !req_ready) && t < MAX_WAIT) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_image();
    int bad;
    bad = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", 32'(bad), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, "_resp_err"},   32'(resp_err),   32'd0);
    chk({tag, "_mem_addr"},   mem_addr,        32'd0);
    chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
    chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
  endtask

  // Monitor: memory-port sequence, response timing/content, handshake invariants
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !resp_valid) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_xfer", 32'(busy), 32'd0);
        end else begin
          mon_m = mem_q.pop_front();
          chk("mem_addr", mem_addr, mon_m.addr);
          chk("mem_we", 32'(mem_we), 32'(mon_m.we));
          if (mon_m.we) chk("mem_wdata", 32'(mem_wdata), 32'(mon_m.wdata));
        end
      end else begin
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
      end
      if (req_ready) chk("ready_busy", 32'(busy), 32'd0);
      if (resp_valid) begin
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          mon_e = exp_q[0];
          if (!seen) begin
            chk("resp_latency", 32'(cyc), 32'(mon_e.due));
            seen = 1'b1;
          end
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_err", 32'(resp_err), 32'(mon_e.err));
          if (resp_ready) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int t;
    logic [2:0]  f3;
    logic        w;
    logic [31:0] a;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    seen        = 1'b0;
    rr_rand     = 1'b0;
    rr_val      = 1'b1;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_funct3  = 3'b000;
    req_addr    = '0;
    req_wdata   = '0;
    for (int i = 0; i < MEM_SZ; i++) begin
      mem[i]     = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Word load
    poke(32'h80, 8'd88); poke(32'h81, 8'd0); poke(32'h82, 8'd0); poke(32'h83, 8'd0);
    issue(1'b0, 3'b010, 32'h80, 32'h0);
    wait_idle();

    // Signed/unsigned byte and half loads
    poke(32'h81, 8'hF0); poke(32'h82, 8'h34); poke(32'h83, 8'h92);
    issue(1'b0, 3'b000, 32'h81, 32'h0);
    issue(1'b0, 3'b100, 32'h81, 32'h0);
    issue(1'b0, 3'b101, 32'h82, 32'h0);
    issue(1'b0, 3'b001, 32'h82, 32'h0);
    wait_idle();

    // Stores, and a load reading back store data
    issue(1'b1, 3'b010, 32'h100, 32'h12345678);
    wait_idle();
    check_image();
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    issue(1'b1, 3'b000, 32'h101, 32'hDEADBEAB);
    wait_idle();
    check_image();

    // Errors and address wrap
    issue(1'b0, 3'b010, 32'h102, 32'h0);
    issue(1'b1, 3'b001, 32'h0FF, 32'hFFFF);
    issue(1'b0, 3'b011, 32'h40, 32'h0);
    issue(1'b1, 3'b100, 32'h40, 32'h0);
    issue(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0);
    wait_idle();
    check_image();

    // Response back-pressure with an ignored request during the stall
    rr_val = 1'b0;
    repeat (2) @(negedge clk);
    issue(1'b0, 3'b010, 32'h80, 32'h0);
    t = 0;
    while (!resp_valid && t < MAX_WAIT) begin
      @(negedge clk);
      t++;
    end
    chk("stall_resp_seen", 32'(resp_valid), 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    rr_val    = 1'b1;
    t = 0;
    while (resp_valid && t < MAX_WAIT) begin
      @(negedge clk);
      t++;
    end
    chk("ready_after_resp", 32'(req_ready), 32'd1);
    wait_idle();
    check_image();

    // Reset in the third byte of a word store
    poke(32'h200, 8'hEE); poke(32'h201, 8'hEE); poke(32'h202, 8'hEE); poke(32'h203, 8'hEE);
    issue(1'b1, 3'b010, 32'h200, 32'hA1B2C3D4);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    mem_q.delete();
    seen = 1'b0;
    ref_mem[mem_idx(32'h202)] = 8'hEE;
    ref_mem[mem_idx(32'h203)] = 8'hEE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_image();
    issue(1'b0, 3'b010, 32'h200, 32'h0);
    wait_idle();

    // Randomized traffic with random back-pressure
    rr_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 9) < 4);
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3) - 1);
      issue(w, f3, a, $urandom);
      if (i % 16 == 15) begin
        wait_idle();
        check_image();
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rr_rand = 1'b0;
    rr_val  = 1'b1;
    wait_idle();
    check_image();
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
